regblock_arbiter: RTL and testbench
===================================

// Module: regblock_arbiter
// PURPOSE
//   Shares one indexed register block (NUM_REGS x DATA_W, per-register write enable, registered read index)
//   between two requesters, A and B. Arbitrates round-robin, with an optional bounded lock for
//   atomic sequences. Drives the register block's write-enable, index and data pins.
//   Routes the 1-cycle-late read data back to the requester that issued the read.
// PARAMETERS
//   DATA_W    32  register width
//   NUM_REGS  2   registers in the shared block; localparam IDX_W = max(1, $clog2(NUM_REGS))
//   MAX_LOCK  8   max cycles one requester may hold the lock before forced release (>=1)
// PORTS
//   clk          in   1       clock; all state updates on posedge
//   rst          in   1       asynchronous, active-low reset
//   x_valid      in   1       request valid (x = a, b; one set of request ports per requester)
//   x_ready      out  1       request accepted this cycle when x_valid & x_ready
//   x_we         in   1       1 = write, 0 = read
//   x_lock       in   1       keep grant after this transaction (atomic sequence)
//   x_idx        in   IDX_W   target register index
//   x_wdata      in   DATA_W  write data
//   x_rsp_valid  out  1       read response valid (1-cycle pulse)
//   x_rsp_data   out  DATA_W  read data
//   x_rsp_err    out  1       index out of range on the accepted request
//   rf_en        out  1       register block write enable
//   rf_wr_index  out  IDX_W   register block write index
//   rf_d         out  DATA_W  register block write data
//   rf_rd_index  out  IDX_W   register block read index (the block registers it internally)
//   rf_q         in   DATA_W  register block read data, valid 1 cycle after rf_rd_index
// BEHAVIOUR
//   - Reset (rst=0, takes effect immediately): FSM=IDLE, rr_ptr=A, lock_cnt=0, all rsp_valid/err=0,
//     rsp_data=0. a_ready, b_ready and rf_en are forced to 0 while reset is asserted.
//     A read in flight when reset asserts is dropped; no response is issued.
//   - At most one transaction is accepted per cycle. x_ready is combinational from FSM and valids.
//   - FSM IDLE: grant the only valid requester. If both are valid, grant rr_ptr.
//     On every accept, rr_ptr <= the other requester.
//   - Accept with x_lock=1 -> OWN_X; lock_cnt <= 1.
//   - OWN_X: only X may be granted; the other requester's ready=0; lock_cnt increments every cycle.
//     - X accepts with x_lock=0 -> IDLE.
//     - lock_cnt==MAX_LOCK -> forced IDLE; rr_ptr <= the other requester.
//       A transaction X accepts in that same cycle completes normally; its lock bit is ignored.
//   - Write accept: rf_en=1, rf_wr_index=x_idx, rf_d=x_wdata in the same cycle.
//     The register updates on the next edge. No response is issued for writes.
//   - Read accept at cycle t: rf_rd_index=x_idx at t.
//     At t+1: x_rsp_valid=1 and x_rsp_data=rf_q (registered response owner).
//   - When no read is accepted, rf_rd_index holds its last driven value. rf_en=0 when no write is accepted.
//   - Read-after-write: a write at t followed by a read of the same idx at t+1 returns the new data at t+2.
//   - Write and read in consecutive cycles from different requesters are legal; no stall.
//   - x_idx >= NUM_REGS: the request is still accepted.
//     - Write: rf_en stays 0.
//     - Read: at t+1, x_rsp_valid=1, x_rsp_data=0, x_rsp_err=1.
//     - x_rsp_err otherwise 0. For an out-of-range write, x_rsp_err pulses at t+1 with no rsp_valid.
//   - Requesters hold valid and payload stable until accepted; the arbiter does not rely on it.
// TESTING
//   1 Reset, then a: write idx0=0xDEADBEEF, read idx0 -> rf_en pulses 1 cycle;
//     a_rsp_valid 1 cycle after the read accept with a_rsp_data=0xDEADBEEF; b_rsp_valid stays 0.
//   2 a and b both read every cycle for 6 cycles -> grants alternate A,B,A,B,A,B;
//     each rsp goes only to its issuer.
//   3 a_lock=1 with both valid continuously, MAX_LOCK=8 -> A owns 8 cycles, b_ready=0 throughout;
//     forced release; next grant is B.
//   4 a read idx=NUM_REGS (out of range) -> accepted, a_rsp_valid=1, a_rsp_err=1, data 0.
//     An out-of-range write leaves rf_en=0.
//   5 rst=0 asserted mid-cycle with a read accepted one cycle earlier -> a_ready/b_ready/rf_en drop
//     immediately; no rsp_valid; after release, FSM=IDLE and a grant to A when both are valid.
//   6 b writes idx1=0x5 at t, a reads idx1 at t+1 -> a_rsp_data=0x5 at t+2.

Source files
------------

// File: rtl/regblock_arbiter.sv
// Round-robin arbiter sharing one indexed register block between requesters A and B,
// with a bounded lock for atomic sequences and 1-cycle-late read data routed back to the issuer.
module regblock_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 2,
  parameter int MAX_LOCK = 8,
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              a_rsp_err,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              b_rsp_err,
  output logic              rf_en,
  output logic [IDX_W-1:0]  rf_wr_index,
  output logic [DATA_W-1:0] rf_d,
  output logic [IDX_W-1:0]  rf_rd_index,
  input  logic [DATA_W-1:0] rf_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;

  localparam int CNT_W  = $clog2(MAX_LOCK + 1);
  localparam int IDX_W1 = IDX_W + 1;
  localparam logic [IDX_W1-1:0] NUM_REGS_L = IDX_W1'(NUM_REGS);
  localparam logic [CNT_W-1:0]  MAX_LOCK_L = CNT_W'(MAX_LOCK);

  logic [1:0]        state;
  logic              rr_b;
  logic [CNT_W-1:0]  lock_cnt;
  logic [IDX_W-1:0]  rd_idx_q;

  logic              grant_a, grant_b;
  logic              acc_a, acc_b, acc, rd_acc, in_range, lock_expire;
  logic              sel_we, sel_lock;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      S_IDLE: begin
        if (a_valid && b_valid) begin
          grant_a = !rr_b;
          grant_b = rr_b;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
      S_OWN_A: grant_a = a_valid;
      S_OWN_B: grant_b = b_valid;
      default: ;
    endcase
  end

  // Readiness is gated by reset so nothing is accepted while rst is low.
  assign a_ready = grant_a & rst;
  assign b_ready = grant_b & rst;
  assign acc_a   = a_valid & a_ready;
  assign acc_b   = b_valid & b_ready;
  assign acc     = acc_a | acc_b;

  assign sel_we    = acc_b ? b_we    : a_we;
  assign sel_lock  = acc_b ? b_lock  : a_lock;
  assign sel_idx   = acc_b ? b_idx   : a_idx;
  assign sel_wdata = acc_b ? b_wdata : a_wdata;

  assign in_range    = {1'b0, sel_idx} < NUM_REGS_L;
  assign rd_acc      = acc & !sel_we;
  assign lock_expire = (state != S_IDLE) && (lock_cnt == MAX_LOCK_L);

  assign rf_en       = acc & sel_we & in_range;
  assign rf_wr_index = sel_idx;
  assign rf_d        = sel_wdata;
  assign rf_rd_index = rd_acc ? sel_idx : rd_idx_q;

  // Out-of-range reads return zero; the block's output is never exposed for them.
  assign a_rsp_data = (a_rsp_valid && !a_rsp_err) ? rf_q : '0;
  assign b_rsp_data = (b_rsp_valid && !b_rsp_err) ? rf_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rr_b        <= 1'b0;
      lock_cnt    <= '0;
      rd_idx_q    <= '0;
      a_rsp_valid <= 1'b0;
      a_rsp_err   <= 1'b0;
      b_rsp_valid <= 1'b0;
      b_rsp_err   <= 1'b0;
    end else begin
      a_rsp_valid <= acc_a & !sel_we;
      a_rsp_err   <= acc_a & !in_range;
      b_rsp_valid <= acc_b & !sel_we;
      b_rsp_err   <= acc_b & !in_range;
      if (rd_acc) rd_idx_q <= sel_idx;
      if (acc) rr_b <= acc_a;
      case (state)
        S_IDLE: begin
          if (acc && sel_lock) begin
            state    <= acc_a ? S_OWN_A : S_OWN_B;
            lock_cnt <= CNT_W'(1);
          end
        end
        S_OWN_A, S_OWN_B: begin
          // Forced release wins over the owner's lock bit and hands priority to the other side.
          if (lock_expire) begin
            state    <= S_IDLE;
            lock_cnt <= '0;
            rr_b     <= (state == S_OWN_A);
          end else if (acc && !sel_lock) begin
            state    <= S_IDLE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regblock_arbiter.sv
// Directed table-driven bench for regblock_arbiter with a 3-entry register block model.
module tb_regblock_arbiter;

  localparam int DW = 32;
  localparam int NR = 3;
  localparam int IW = 2;
  localparam int NROWS = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 0, a_we = 0, a_lock = 0;
  logic [IW-1:0] a_idx = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_valid = 0, b_we = 0, b_lock = 0;
  logic [IW-1:0] b_idx = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ready, b_ready, a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err, rf_en;
  logic [DW-1:0] a_rsp_data, b_rsp_data, rf_d, rf_q;
  logic [IW-1:0] rf_wr_index, rf_rd_index;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  always #5 clk = ~clk;

  regblock_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_lock(a_lock), .a_idx(a_idx),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_lock(b_lock), .b_idx(b_idx),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
    .rf_en(rf_en), .rf_wr_index(rf_wr_index), .rf_d(rf_d), .rf_rd_index(rf_rd_index), .rf_q(rf_q)
  );

  // Register block model: write on edge, read index registered inside the block.
  logic [DW-1:0] mem [NR];
  logic [IW-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (rf_en && rf_wr_index < IW'(NR)) mem[rf_wr_index] <= rf_d;
    rd_q <= rf_rd_index;
  end
  assign rf_q = (rd_q < IW'(NR)) ? mem[rd_q] : 32'hBAD0BAD0;

  typedef struct {
    bit            rs;
    logic          av, awe, alk;
    logic [IW-1:0] ai;
    logic [DW-1:0] ad;
    logic          bv, bwe, blk;
    logic [IW-1:0] bi;
    logic [DW-1:0] bd;
    logic          ear, ebr, een;
    logic [IW-1:0] erd;
    logic          eav, eae;
    logic [DW-1:0] ead;
    logic          ebv, ebe;
    logic [DW-1:0] ebd;
  } vec_t;

  vec_t tbl [NROWS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, cur, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_we = 0; a_lock = 0; a_idx = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_lock = 0; b_idx = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    if (v.rs) do_reset();
    a_valid = v.av; a_we = v.awe; a_lock = v.alk; a_idx = v.ai; a_wdata = v.ad;
    b_valid = v.bv; b_we = v.bwe; b_lock = v.blk; b_idx = v.bi; b_wdata = v.bd;
    #1;
    chk("a_ready", 32'(a_ready), 32'(v.ear));
    chk("b_ready", 32'(b_ready), 32'(v.ebr));
    chk("rf_en", 32'(rf_en), 32'(v.een));
    chk("rf_rd_index", 32'(rf_rd_index), 32'(v.erd));
    chk("a_rsp_valid", 32'(a_rsp_valid), 32'(v.eav));
    chk("a_rsp_err", 32'(a_rsp_err), 32'(v.eae));
    chk("a_rsp_data", a_rsp_data, v.ead);
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(v.ebv));
    chk("b_rsp_err", 32'(b_rsp_err), 32'(v.ebe));
    chk("b_rsp_data", b_rsp_data, v.ebd);
    if (v.een) begin
      chk("rf_wr_index", 32'(rf_wr_index), v.ear ? 32'(v.ai) : 32'(v.bi));
      chk("rf_d", rf_d, v.ear ? v.ad : v.bd);
    end
    @(negedge clk);
  endtask

  initial begin
    // rs | a: v we lk idx data | b: v we lk idx data | exp: a_rdy b_rdy en rd_idx | a_rsp v err data | b_rsp v err data
    // Write then read-back by A; then B writes idx1 and A reads it next cycle.
    tbl[0]  = '{1, 1,1,0,0,32'hDEADBEEF, 0,0,0,0,0,  1,0,1,0, 0,0,0,            0,0,0};
    tbl[1]  = '{0, 1,0,0,0,0,            0,0,0,0,0,  1,0,0,0, 0,0,0,            0,0,0};
    tbl[2]  = '{0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0, 1,0,32'hDEADBEEF, 0,0,0};
    tbl[3]  = '{0, 0,0,0,0,0,            1,1,0,1,5,  0,1,1,0, 0,0,0,            0,0,0};
    tbl[4]  = '{0, 1,0,0,1,0,            0,0,0,0,0,  1,0,0,1, 0,0,0,            0,0,0};
    tbl[5]  = '{0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,1, 1,0,5,            0,0,0};
    // Both read every cycle: grants alternate A,B,... and responses return to the issuer.
    tbl[6]  = '{1, 1,0,0,0,0,            1,0,0,1,0,  1,0,0,0, 0,0,0,            0,0,0};
    tbl[7]  = '{0, 1,0,0,0,0,            1,0,0,1,0,  0,1,0,1, 1,0,32'hDEADBEEF, 0,0,0};
    tbl[8]  = '{0, 1,0,0,0,0,            1,0,0,1,0,  1,0,0,0, 0,0,0,            1,0,5};
    tbl[9]  = '{0, 1,0,0,0,0,            1,0,0,1,0,  0,1,0,1, 1,0,32'hDEADBEEF, 0,0,0};
    tbl[10] = '{0, 1,0,0,0,0,            1,0,0,1,0,  1,0,0,0, 0,0,0,            1,0,5};
    tbl[11] = '{0, 1,0,0,0,0,            1,0,0,1,0,  0,1,0,1, 1,0,32'hDEADBEEF, 0,0,0};
    tbl[12] = '{0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,1, 0,0,0,            1,0,5};
    // Out-of-range read and write (idx == NUM_REGS).
    tbl[13] = '{0, 1,0,0,3,0,            0,0,0,0,0,  1,0,0,3, 0,0,0,            0,0,0};
    tbl[14] = '{0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,3, 1,1,0,            0,0,0};
    tbl[15] = '{0, 1,1,0,3,32'h1234,     0,0,0,0,0,  1,0,0,3, 0,0,0,            0,0,0};
    tbl[16] = '{0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,3, 0,1,0,            0,0,0};
    tbl[17] = '{0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,3, 0,0,0,            0,0,0};
    // A holds the lock: accept in IDLE plus 8 owned cycles, then forced release to B.
    for (int i = 18; i <= 26; i++)
      tbl[i] = '{(i == 18), 1,1,1,2,32'hA, 1,1,0,2,32'hB, 1,0,1,0, 0,0,0, 0,0,0};
    tbl[27] = '{0, 1,1,1,2,32'hA,        1,1,0,2,32'hB, 0,1,1,0, 0,0,0,         0,0,0};
    // Lock taken, then released early by an unlocked transaction.
    tbl[28] = '{0, 1,1,1,2,32'hA,        1,1,0,2,32'hB, 1,0,1,0, 0,0,0,         0,0,0};
    tbl[29] = '{0, 1,1,0,2,32'hA,        1,1,0,2,32'hB, 1,0,1,0, 0,0,0,         0,0,0};
    tbl[30] = '{0, 1,1,0,2,32'hA,        1,1,0,2,32'hB, 0,1,1,0, 0,0,0,         0,0,0};

    // Reset state, with both requesters pushing.
    idle_inputs();
    a_valid = 1; b_valid = 1; b_we = 1;
    @(negedge clk);
    #1;
    cur = -1;
    chk("rst a_ready", 32'(a_ready), 32'd0);
    chk("rst b_ready", 32'(b_ready), 32'd0);
    chk("rst rf_en", 32'(rf_en), 32'd0);
    chk("rst a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst b_rsp_err", 32'(b_rsp_err), 32'd0);
    chk("rst a_rsp_data", a_rsp_data, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    for (int r = 0; r < NROWS; r++) begin
      cur = r;
      apply(tbl[r]);
    end

    // Asynchronous reset asserted mid-cycle, one cycle after a read accept.
    cur = 100;
    a_valid = 1; a_we = 0; a_idx = 0;
    b_valid = 1; b_we = 1; b_idx = 1; b_wdata = 32'h7;
    #1;
    chk("pre a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("pre b_ready", 32'(b_ready), 32'd1);
    chk("pre rf_en", 32'(rf_en), 32'd1);
    chk("pre a_rsp_valid", 32'(a_rsp_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid a_ready", 32'(a_ready), 32'd0);
    chk("mid b_ready", 32'(b_ready), 32'd0);
    chk("mid rf_en", 32'(rf_en), 32'd0);
    chk("mid a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("mid b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("held a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("held b_rsp_err", 32'(b_rsp_err), 32'd0);
    chk("held a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    b_we = 0;
    #1;
    chk("post a_ready", 32'(a_ready), 32'd1);
    chk("post b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post a_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("post a_rsp_data", a_rsp_data, 32'hDEADBEEF);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
